// File: rtl/laser_scheduler.sv
`timescale 1ns/1ps
// laser_scheduler: owns the player laser pool in the play state. Fire-key presses become
// pending shot requests that are allocated to the lowest free slot on a frame tick. Every
// frame tick each live laser is first checked for a hit, then moved up, then a new shot
// may be placed.
// Optional feature macro: LASER_AUTOFIRE_EN. When defined, a held fire key re-arms the
// shot request every Clk, so holding the key fires at every READY opportunity.
module laser_scheduler #(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned SLOT_W          = 2,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned LASER_SPEED     = 6,
    parameter logic [7:0]  FIRE_KEY        = 8'h2C,
    parameter int unsigned X_OFFSET        = 7
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    play,
    input  logic [7:0]              keycode,
    input  logic [9:0]              x_pos,
    input  logic [9:0]              y_pos,
    input  logic                    hit_valid,
    input  logic [SLOT_W-1:0]       hit_slot,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [NUM_SLOTS*10-1:0] slot_x,
    output logic [NUM_SLOTS*10-1:0] slot_y,
    output logic                    fire_ack,
    output logic [15:0]             shots_fired
);

    localparam int unsigned CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [9:0] SPEED = 10'(LASER_SPEED);
    localparam logic [9:0] XOFF  = 10'(X_OFFSET);

    typedef enum logic [1:0] {StIdle, StReady, StCool} state_e;

    state_e                      state_q, state_d;
    logic [CD_W-1:0]             cool_q, cool_d;
    logic                        pend_q, pend_d;
    logic                        press_q;
    logic                        fc_meta_q, fc_sync_q, fc_prev_q;
    logic [NUM_SLOTS-1:0]        act_q, act_d;
    logic [NUM_SLOTS-1:0][9:0]   x_q, x_d, y_q, y_d;
    logic                        ack_q, ack_d;
    logic [15:0]                 shots_q, shots_d;

    logic                        press;
    logic                        press_set;
    logic                        frame_tick;
    logic                        found;
    logic [SLOT_W-1:0]           free_idx;

    assign press      = (keycode == FIRE_KEY);
    assign frame_tick = fc_sync_q & ~fc_prev_q;

`ifdef LASER_AUTOFIRE_EN
    assign press_set = press;
`else
    assign press_set = press & ~press_q;
`endif

    assign slot_active = act_q;
    assign slot_x      = x_q;
    assign slot_y      = y_q;
    assign fire_ack    = ack_q;
    assign shots_fired = shots_q;

    // Next-state: play gating, hit/advance/allocate ordering and the cooldown FSM.
    always_comb begin
        state_d  = state_q;
        cool_d   = cool_q;
        pend_d   = pend_q | press_set;
        act_d    = act_q;
        x_d      = x_q;
        y_d      = y_q;
        ack_d    = 1'b0;
        shots_d  = shots_q;
        found    = 1'b0;
        free_idx = '0;

        if (!play) begin
            state_d = StIdle;
            act_d   = '0;
            x_d     = '0;
            y_d     = '0;
            cool_d  = '0;
            pend_d  = 1'b0;
        end else if (state_q == StIdle) begin
            state_d = StReady;
            pend_d  = 1'b0;
        end else begin
            // A hit on an already inactive slot leaves it inactive, so no guard is needed.
            if (hit_valid) begin
                act_d[hit_slot] = 1'b0;
            end
            if (frame_tick) begin
                // The request is consumed by this tick whether or not it is granted.
                pend_d = 1'b0;
                for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                    if (act_d[i]) begin
                        if (y_q[i] < SPEED) begin
                            act_d[i] = 1'b0;
                        end else begin
                            y_d[i] = y_q[i] - SPEED;
                        end
                    end
                end
                if (state_q == StCool) begin
                    cool_d = cool_q - CD_W'(1);
                    if (cool_q == CD_W'(1)) begin
                        state_d = StReady;
                    end
                end else if (pend_q) begin
                    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                        if (!found && !act_d[i]) begin
                            found    = 1'b1;
                            free_idx = SLOT_W'(i);
                        end
                    end
                    // A full pool drops the shot and stays READY.
                    if (found) begin
                        act_d[free_idx] = 1'b1;
                        x_d[free_idx]   = x_pos + XOFF;
                        y_d[free_idx]   = y_pos;
                        ack_d           = 1'b1;
                        if (shots_q != 16'hFFFF) begin
                            shots_d = shots_q + 16'd1;
                        end
                        if (COOLDOWN_FRAMES != 0) begin
                            state_d = StCool;
                            cool_d  = CD_LOAD;
                        end
                    end
                end
            end
        end
    end

    // State registers, frame_clk synchronizer and fire-key history.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            cool_q    <= '0;
            pend_q    <= 1'b0;
            press_q   <= 1'b0;
            fc_meta_q <= 1'b0;
            fc_sync_q <= 1'b0;
            fc_prev_q <= 1'b0;
            act_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ack_q     <= 1'b0;
            shots_q   <= '0;
        end else begin
            state_q   <= state_d;
            cool_q    <= cool_d;
            pend_q    <= pend_d;
            press_q   <= press;
            fc_meta_q <= frame_clk;
            fc_sync_q <= fc_meta_q;
            fc_prev_q <= fc_sync_q;
            act_q     <= act_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ack_q     <= ack_d;
            shots_q   <= shots_d;
        end
    end

endmodule
